// File: rtl/rr_mux8_sched.sv
// rr_mux8_sched: round-robin burst scheduler driving the select/enable of a shared 8:1 mux
module rr_mux8_sched #(
  parameter int MAX_BEATS = 0,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic       dst_ready,
  output logic [2:0] mux_sel,
  output logic       mux_en,
  output logic [7:0] gnt,
  output logic       beat,
  output logic       abort
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d, ptr_q, ptr_d;
  logic             en_q, en_d, abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idle_win, rel_win;
  logic             lim, rel;
  // {found, index} of the first set bit after p, wrapping so p itself is checked last
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction
  assign beat     = en_q & req[sel_q] & dst_ready;
  assign lim      = (MAX_BEATS != 0) && (cnt_q == CNT_W'(MAX_BEATS - 1));
  assign rel      = beat & (last[sel_q] | lim);
  assign idle_win = pick(req, ptr_q);
  assign rel_win  = pick(req & ~(8'd1 << sel_q), sel_q);
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    abort_d = 1'b0;
    if (state_q == IDLE) begin
      if (idle_win[3]) begin
        state_d = BUSY;
        sel_d   = idle_win[2:0];
        en_d    = 1'b1;
        cnt_d   = '0;
      end
    end else if (rel) begin
      ptr_d   = sel_q;
      cnt_d   = '0;
      sel_d   = rel_win[3] ? rel_win[2:0] : sel_q;
      state_d = rel_win[3] ? BUSY : IDLE;
      en_d    = rel_win[3];
    end else if (!req[sel_q]) begin
      abort_d = 1'b1;
      ptr_d   = sel_q;
      state_d = IDLE;
      en_d    = 1'b0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 3'd7;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end
  assign mux_sel = sel_q;
  assign mux_en  = en_q;
  assign abort   = abort_q;
  assign gnt     = en_q ? (8'd1 << sel_q) : 8'd0;
endmodule

// File: tb/tb_rr_mux8_sched.sv
// tb_rr_mux8_sched: directed checks of an unlimited-burst and a 4-beat-limited scheduler
module tb_rr_mux8_sched;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = '0, last = '0;
  logic       dst_ready = 1'b0;
  logic [2:0] sel0, sel4;
  logic       en0, en4, beat0, beat4, abort0, abort4;
  logic [7:0] gnt0, gnt4;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  rr_mux8_sched #(.MAX_BEATS(0), .CNT_W(8)) u0 (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last), .dst_ready(dst_ready),
    .mux_sel(sel0), .mux_en(en0), .gnt(gnt0), .beat(beat0), .abort(abort0));
  rr_mux8_sched #(.MAX_BEATS(4), .CNT_W(8)) u4 (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last), .dst_ready(dst_ready),
    .mux_sel(sel4), .mux_en(en4), .gnt(gnt4), .beat(beat4), .abort(abort4));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0; req = '0; last = '0; dst_ready = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0; req = 8'hFF; last = 8'hFF; dst_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({en0, sel0, gnt0, beat0, abort0} !== 14'd0) begin
      n_fail++; $display("FAIL reset_u0 got en=%0b sel=%0d gnt=%h beat=%0b abort=%0b exp all 0", en0, sel0, gnt0, beat0, abort0);
    end
    n_tests++;
    if ({en4, sel4, gnt4, beat4, abort4} !== 14'd0) begin
      n_fail++; $display("FAIL reset_u4 got en=%0b sel=%0d gnt=%h beat=%0b abort=%0b exp all 0", en4, sel4, gnt4, beat4, abort4);
    end
    reset_n = 1'b1; req = '0; last = '0;
    tick();
  endtask
  task automatic test_single();
    do_reset();
    req = 8'h01; dst_ready = 1'b1; last = '0;
    #1;
    n_tests++;
    if (en0 !== 1'b0) begin n_fail++; $display("FAIL single_latency got en=%0b exp 0", en0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      last = (i == 2) ? 8'h01 : 8'h00;
      #1;
      n_tests++;
      if ({en0, sel0, gnt0, beat0} !== {1'b1, 3'd0, 8'h01, 1'b1}) begin
        n_fail++; $display("FAIL single_beat[%0d] got en=%0b sel=%0d gnt=%h beat=%0b exp 1/0/01/1", i, en0, sel0, gnt0, beat0);
      end
    end
    tick();
    req = '0; last = '0;
    n_tests++;
    if ({en0, gnt0, beat0} !== 10'd0) begin
      n_fail++; $display("FAIL single_release got en=%0b gnt=%h beat=%0b exp 0", en0, gnt0, beat0);
    end
  endtask
  task automatic test_fairness();
    do_reset();
    req = 8'hFF; last = 8'hFF; dst_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++;
      if ({en0, sel0, gnt0, beat0} !== {1'b1, 3'(i % 8), 8'(1 << (i % 8)), 1'b1}) begin
        n_fail++; $display("FAIL fair[%0d] got en=%0b sel=%0d gnt=%h beat=%0b exp 1/%0d/%h/1", i, en0, sel0, gnt0, beat0, i % 8, 8'(1 << (i % 8)));
      end
    end
    req = '0; last = '0;
  endtask
  task automatic test_max_beats();
    logic [2:0] exp_sel;
    do_reset();
    req = 8'h21; last = '0; dst_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_sel = ((k / 4) % 2 == 1) ? 3'd5 : 3'd0;
      n_tests++;
      if ({en4, sel4, beat4, abort4} !== {1'b1, exp_sel, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL maxb[%0d] got en=%0b sel=%0d beat=%0b abort=%0b exp 1/%0d/1/0", k, en4, sel4, beat4, abort4, exp_sel);
      end
    end
    req = '0;
  endtask
  task automatic test_backpressure();
    do_reset();
    req = 8'h04; last = '0; dst_ready = 1'b1;
    tick();
    tick();
    tick();
    dst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({en0, sel0, beat0, en4, sel4, beat4} !== {1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 1'b0}) begin
        n_fail++; $display("FAIL bp_stall[%0d] got u0 %0b/%0d/%0b u4 %0b/%0d/%0b exp 1/2/0", i, en0, sel0, beat0, en4, sel4, beat4);
      end
      tick();
    end
    dst_ready = 1'b1;
    tick();
    n_tests++;
    if ({en4, sel4} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL bp_freeze got en=%0b sel=%0d exp 1/2", en4, sel4); end
    tick();
    n_tests++;
    if ({en4, en0, sel0} !== {1'b0, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL bp_limit got u4 en=%0b u0 en=%0b sel=%0d exp 0/1/2", en4, en0, sel0);
    end
    dst_ready = 1'b0; last = 8'h04;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({en0, sel0, beat0} !== {1'b1, 3'd2, 1'b0}) begin
        n_fail++; $display("FAIL bp_last_stall[%0d] got en=%0b sel=%0d beat=%0b exp 1/2/0", i, en0, sel0, beat0);
      end
      tick();
    end
    dst_ready = 1'b1;
    #1;
    n_tests++;
    if (beat0 !== 1'b1) begin n_fail++; $display("FAIL bp_beat got %0b exp 1", beat0); end
    tick();
    n_tests++;
    if (en0 !== 1'b0) begin n_fail++; $display("FAIL bp_release got en=%0b exp 0", en0); end
    req = '0; last = '0;
  endtask
  task automatic test_abort();
    do_reset();
    req = 8'h08; last = '0; dst_ready = 1'b1;
    tick();
    n_tests++;
    if ({en0, sel0, gnt0} !== {1'b1, 3'd3, 8'h08}) begin
      n_fail++; $display("FAIL abort_grant got en=%0b sel=%0d gnt=%h exp 1/3/08", en0, sel0, gnt0);
    end
    tick();
    req = 8'h40;
    #1;
    n_tests++;
    if ({beat0, abort0} !== 2'b00) begin n_fail++; $display("FAIL abort_drop got beat=%0b abort=%0b exp 0/0", beat0, abort0); end
    tick();
    n_tests++;
    if ({abort0, en0, gnt0} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL abort_pulse got abort=%0b en=%0b gnt=%h exp 1/0/00", abort0, en0, gnt0);
    end
    tick();
    n_tests++;
    if ({abort0, en0, sel0, gnt0} !== {1'b0, 1'b1, 3'd6, 8'h40}) begin
      n_fail++; $display("FAIL abort_regrant got abort=%0b en=%0b sel=%0d gnt=%h exp 0/1/6/40", abort0, en0, sel0, gnt0);
    end
    req = '0;
  endtask
  task automatic test_async_reset();
    do_reset();
    req = 8'h10; last = '0; dst_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({en0, sel0} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL ar_busy got en=%0b sel=%0d exp 1/4", en0, sel0); end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({en0, sel0, gnt0, beat0, abort0} !== 14'd0) begin
      n_fail++; $display("FAIL ar_clear got en=%0b sel=%0d gnt=%h beat=%0b abort=%0b exp all 0", en0, sel0, gnt0, beat0, abort0);
    end
    tick();
    reset_n = 1'b1; req = 8'h11;
    tick();
    n_tests++;
    if ({en0, sel0, abort0} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL ar_prio got en=%0b sel=%0d abort=%0b exp 1/0/0", en0, sel0, abort0);
    end
    req = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_max_beats();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
